// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Register byte offsets on the data-memory bus
    localparam logic [3:0] UART_OFF_TXDATA  = 4'h0;
    localparam logic [3:0] UART_OFF_STATUS  = 4'h4;
    localparam logic [3:0] UART_OFF_BAUDDIV = 4'h8;

    // STATUS bit positions
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    // Assemble the STATUS read word; upper bits read as zero
    function automatic logic [31:0] status_word(
        input logic full,
        input logic empty,
        input logic busy,
        input logic ovf
    );
        logic [31:0] w;
        w            = '0;
        w[STAT_FULL]  = full;
        w[STAT_EMPTY] = empty;
        w[STAT_BUSY]  = busy;
        w[STAT_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous first-word-fall-through FIFO used as the UART transmit buffer.
// Head data is visible combinationally so the FSM can load it on the pop edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_push_ok;
    logic w_pop_ok;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push while full is still accepted when a pop frees the head slot
    assign w_push_ok = push && (!full || pop);
    assign w_pop_ok  = pop && !empty;

    assign dout = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; wrap-around is carried by the extra MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, baud divisor,
// sticky overflow flag, transmit FIFO and the serialising FSM.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 868,
    parameter int DIV_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    // Bus write decode
    logic w_push;
    logic w_stat_wr;
    logic w_div_wr;

    assign w_push    = sel_i && we_i && (addr_i == UART_OFF_TXDATA);
    assign w_stat_wr = sel_i && we_i && (addr_i == UART_OFF_STATUS);
    assign w_div_wr  = sel_i && we_i && (addr_i == UART_OFF_BAUDDIV);

    // Bits of the store data that no register keeps
    logic w_unused_wdata;
    assign w_unused_wdata = ^wdata_i[31:DIV_W];

    // Registers
    logic [DIV_W-1:0] r_div;
    logic             r_ovf;
    uart_state_t      r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [DIV_W-1:0] r_frame_div;
    logic             r_tx;

    // FIFO interface
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [7:0] w_fifo_dout;
    logic       w_pop;
    logic       w_bit_end;

    assign w_bit_end = (r_baud_cnt == '0);

    // A new frame starts from IDLE, or directly out of the last STOP cycle
    // so back-to-back frames have no idle gap.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (wdata_i[7:0]),
        .pop   (w_pop),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .dout  (w_fifo_dout)
    );

    // Baud divisor register; zero would stall the counter so it is stored as 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DIV_W'(DIV_RESET);
        end else if (w_div_wr) begin
            if (wdata_i[DIV_W-1:0] == '0) begin
                r_div <= DIV_W'(1);
            end else begin
                r_div <= wdata_i[DIV_W-1:0];
            end
        end
    end

    // Sticky overflow: set when a byte is dropped, cleared by any STATUS write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_stat_wr) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_fifo_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    // Transmit FSM with registered serial output and baud/bit counters.
    // The divisor is latched per frame so mid-frame BAUDDIV writes only
    // take effect on the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tx        <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_baud_cnt  <= '0;
            r_frame_div <= DIV_W'(DIV_RESET);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state     <= START;
                        r_tx        <= 1'b0;
                        r_shift     <= w_fifo_dout;
                        r_bit_cnt   <= '0;
                        r_baud_cnt  <= r_div - 1'b1;
                        r_frame_div <= r_div;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state    <= DATA;
                        r_tx       <= r_shift[0];
                        r_baud_cnt <= r_frame_div - 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_frame_div - 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_state     <= START;
                            r_tx        <= 1'b0;
                            r_shift     <= w_fifo_dout;
                            r_bit_cnt   <= '0;
                            r_baud_cnt  <= r_div - 1'b1;
                            r_frame_div <= r_div;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o  = r_tx;
    assign irq_o = w_fifo_empty && (r_state == IDLE);

    // Combinational read mux; the single-cycle core needs load data this cycle
    always_comb begin
        rdata_o = '0;
        if (sel_i) begin
            case (addr_i)
                UART_OFF_STATUS: begin
                    rdata_o = status_word(w_fifo_full, w_fifo_empty,
                                          (r_state != IDLE), r_ovf);
                end
                UART_OFF_BAUDDIV: begin
                    rdata_o = 32'(r_div);
                end
                default: begin
                    rdata_o = '0;
                end
            endcase
        end
    end

endmodule
